// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 strip driver: FSM encoding, 50 MHz timing defaults,
// and the RGB to GRB wire-order helper.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_t;

  localparam int DEF_T0H          = 20;
  localparam int DEF_T0L          = 42;
  localparam int DEF_T1H          = 40;
  localparam int DEF_T1L          = 22;
  localparam int DEF_LATCH_CYCLES = 15000;

  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/ws2812_pixel_scaler.sv
// Combinational colour capture path: optional brightness scaling, then GRB reorder (MSB goes first on the wire).
// Macro WS2812_BRIGHTNESS_EN adds the brightness input; without it channels pass unchanged.
module ws2812_pixel_scaler
  import ws2812_pkg::*;
(
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]  brightness,
`endif
  input  logic [23:0] rgb,
  output logic [23:0] grb
);

`ifdef WS2812_BRIGHTNESS_EN
  // brightness+1 makes 255 an exact identity: c*256>>8 == c
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [8:0]  mult;
    logic [16:0] prod;
    mult = {1'b0, b} + 9'd1;
    prod = {9'b0, c} * {8'b0, mult};
    return prod[15:8];
  endfunction

  assign grb = rgb_to_grb({scale(rgb[23:16], brightness),
                           scale(rgb[15:8],  brightness),
                           scale(rgb[7:0],   brightness)});
`else
  assign grb = rgb_to_grb(rgb);
`endif

endmodule

// File: rtl/ws2812_strip_driver.sv
// Serializes num_leds 24-bit pixels onto the WS2812 single-wire line, then holds the latch low period.
// Next pixel is prefetched during bit 0 of the current one so bit timing has no gap at pixel boundaries.
// Optional macro WS2812_BRIGHTNESS_EN adds a brightness input latched at start.
module ws2812_strip_driver
  import ws2812_pkg::*;
#(
  parameter int T0H          = DEF_T0H,
  parameter int T0L          = DEF_T0L,
  parameter int T1H          = DEF_T1H,
  parameter int T1L          = DEF_T1L,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  num_leds,
  input  logic [23:0] pixel_color,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]  brightness,
`endif
  output logic        pixel_req,
  output logic [9:0]  pixel_idx,
  output logic        busy,
  output logic        done,
  output logic        dout
);

  localparam int CW = $clog2(LATCH_CYCLES + 1);
  localparam logic [CW-1:0] T0H_M1   = CW'(T0H - 1);
  localparam logic [CW-1:0] T0L_M1   = CW'(T0L - 1);
  localparam logic [CW-1:0] T1H_M1   = CW'(T1H - 1);
  localparam logic [CW-1:0] T1L_M1   = CW'(T1L - 1);
  localparam logic [CW-1:0] LATCH_M1 = CW'(LATCH_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [4:0]    bit_q;
  logic [23:0]   shreg_q;
  logic [23:0]   pf_q;
  logic [9:0]    num_q;
  logic [9:0]    cur_q;
  logic [9:0]    idx_q;
  logic          pf_req_q;
  logic          pf_cap_q;
  logic [23:0]   scaled;

  logic cnt_zero, more_bits, more_pix, pf_next;
  assign cnt_zero  = (cnt_q == '0);
  assign more_bits = (bit_q != 5'd23);
  assign more_pix  = (({1'b0, cur_q} + 11'd1) < {1'b0, num_q});
  assign pf_next   = (({1'b0, cur_q} + 11'd2) < {1'b0, num_q});

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] bri_q;
  ws2812_pixel_scaler u_scaler (
    .brightness (bri_q),
    .rgb        (pixel_color),
    .grb        (scaled)
  );
`else
  ws2812_pixel_scaler u_scaler (
    .rgb (pixel_color),
    .grb (scaled)
  );
`endif

  function automatic logic [CW-1:0] high_len(input logic b);
    return b ? T1H_M1 : T0H_M1;
  endfunction

  function automatic logic [CW-1:0] low_len(input logic b);
    return b ? T1L_M1 : T0L_M1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && num_leds != '0) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_HIGH;
      ST_HIGH:  if (cnt_zero) state_d = ST_LOW;
      ST_LOW:   if (cnt_zero) state_d = (more_bits || more_pix) ? ST_HIGH : ST_LATCH;
      ST_LATCH: if (cnt_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pixel_req = (state_q == ST_FETCH) || pf_req_q;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_LATCH) && cnt_zero;
    dout      = (state_q == ST_HIGH);
    pixel_idx = idx_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      pf_q     <= '0;
      num_q    <= '0;
      cur_q    <= '0;
      idx_q    <= '0;
      pf_req_q <= 1'b0;
      pf_cap_q <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
      bri_q    <= '0;
`endif
    end else begin
      pf_req_q <= 1'b0;
      pf_cap_q <= pf_req_q;
      // upstream answers a request on the following cycle
      if (pf_cap_q) pf_q <= scaled;
      case (state_q)
        ST_IDLE: begin
          if (start && num_leds != '0) begin
            num_q <= num_leds;
            idx_q <= '0;
            cur_q <= '0;
`ifdef WS2812_BRIGHTNESS_EN
            bri_q <= brightness;
`endif
          end
        end
        ST_LOAD: begin
          shreg_q <= scaled;
          bit_q   <= '0;
          cnt_q   <= high_len(scaled[23]);
          if (num_q > 10'd1) begin
            idx_q    <= 10'd1;
            pf_req_q <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt_zero) cnt_q <= low_len(shreg_q[23]);
          else          cnt_q <= cnt_q - 1'b1;
        end
        ST_LOW: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (more_bits) begin
            shreg_q <= {shreg_q[22:0], 1'b0};
            bit_q   <= bit_q + 5'd1;
            cnt_q   <= high_len(shreg_q[22]);
          end else if (more_pix) begin
            shreg_q <= pf_q;
            cur_q   <= cur_q + 10'd1;
            bit_q   <= '0;
            cnt_q   <= high_len(pf_q[23]);
            if (pf_next) begin
              idx_q    <= cur_q + 10'd2;
              pf_req_q <= 1'b1;
            end
          end else begin
            cnt_q <= LATCH_M1;
          end
        end
        ST_LATCH: begin
          if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Bench for ws2812_strip_driver: table of frames plus random frames, checked against a waveform model
// built from bit timing arithmetic; latch period shortened to keep runs short.
module tb_ws2812_strip_driver;

  localparam int P_T0H = 20;
  localparam int P_T0L = 42;
  localparam int P_T1H = 40;
  localparam int P_T1L = 22;
  localparam int LAT   = 1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  num_leds;
  logic [23:0] pixel_color = '0;
  logic        pixel_req;
  logic [9:0]  pixel_idx;
  logic        busy;
  logic        done;
  logic        dout;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif

  always #5 clock = ~clock;

  ws2812_strip_driver #(
    .T0H(P_T0H), .T0L(P_T0L), .T1H(P_T1H), .T1L(P_T1L), .LATCH_CYCLES(LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_leds    (num_leds),
    .pixel_color (pixel_color),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness  (brightness),
`endif
    .pixel_req   (pixel_req),
    .pixel_idx   (pixel_idx),
    .busy        (busy),
    .done        (done),
    .dout        (dout)
  );

  // Upstream colour source: answers a request and holds the value until the next one.
  logic [23:0] colours [0:1023];
  always @(negedge clock) if (pixel_req) pixel_color = colours[pixel_idx];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Bytes as they should appear on the wire: scale each channel, send G, R, B.
  function automatic logic [23:0] wire_grb(input logic [23:0] rgb, input logic [7:0] b);
    int r, g, bl;
    r  = int'(rgb[23:16]) * (int'(b) + 1) / 256;
    g  = int'(rgb[15:8])  * (int'(b) + 1) / 256;
    bl = int'(rgb[7:0])   * (int'(b) + 1) / 256;
    return {g[7:0], r[7:0], bl[7:0]};
  endfunction

  task automatic run_frame(input int n, input int done_exp, input bit disturb,
                           input logic [7:0] bri, output logic [23:0] px0);
    int pstart[$];
    int bits_got[$];
    int rq_off[$], rq_idx[$];
    logic dq[$], bq[$], kq[$];
    logic edq[];
    int pos, done_m, last_off, first_done, dwave, bwave, kwave, qmis, h, got;
    logic [23:0] g;
    logic [23:0] acc;

    pos = 3;
    for (int k = 0; k < n; k++) begin
      pstart.push_back(pos);
      g = wire_grb(colours[k], bri);
      for (int b = 23; b >= 0; b--) pos += g[b] ? (P_T1H + P_T1L) : (P_T0H + P_T0L);
    end
    done_m   = (done_exp >= 0) ? done_exp : (pos + LAT - 1);
    last_off = pos + LAT + 2;

    edq = new[last_off + 1];
    foreach (edq[i]) edq[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      g   = wire_grb(colours[k], bri);
      pos = pstart[k];
      for (int b = 23; b >= 0; b--) begin
        for (int c = 0; c < (g[b] ? P_T1H : P_T0H); c++) edq[pos + c] = 1'b1;
        pos += g[b] ? (P_T1H + P_T1L) : (P_T0H + P_T0L);
      end
    end

    @(negedge clock);
    num_leds = 10'(n);
`ifdef WS2812_BRIGHTNESS_EN
    brightness = bri;
`endif
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int off = 1; off <= last_off; off++) begin
      dq.push_back(dout);
      bq.push_back(busy);
      kq.push_back(done);
      if (pixel_req) begin
        rq_off.push_back(off);
        rq_idx.push_back(int'(pixel_idx));
      end
      if (disturb && off == 500) begin
        start    = 1'b1;
        num_leds = 10'(n + 3);
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end

    dwave = 0; bwave = 0; kwave = 0; first_done = -1;
    for (int off = 1; off <= last_off; off++) begin
      if (dq[off-1] !== edq[off]) dwave++;
      if (bq[off-1] !== (off <= done_m)) bwave++;
      if (kq[off-1] !== (off == done_m)) kwave++;
      if (first_done < 0 && kq[off-1] === 1'b1) first_done = off;
    end
    check($sformatf("n%0d_done_cycle", n), first_done, done_m);
    check($sformatf("n%0d_dout_wave_errs", n), dwave, 0);
    check($sformatf("n%0d_busy_wave_errs", n), bwave, 0);
    check($sformatf("n%0d_done_wave_errs", n), kwave, 0);

    qmis = 0;
    check($sformatf("n%0d_req_count", n), rq_off.size(), n);
    for (int k = 0; k < n && k < rq_off.size(); k++) begin
      if (rq_idx[k] != k) qmis++;
      if (rq_off[k] != ((k == 0) ? 1 : pstart[k-1])) qmis++;
    end
    check($sformatf("n%0d_req_errs", n), qmis, 0);

    for (int off = 1; off <= last_off; off++) begin
      if (dq[off-1] === 1'b1 && (off == 1 || dq[off-2] !== 1'b1)) begin
        h = 0;
        while (off + h <= last_off && dq[off+h-1] === 1'b1) h++;
        bits_got.push_back((2 * h > P_T0H + P_T1H) ? 1 : 0);
      end
    end
    px0 = 'x;
    for (int k = 0; k < n; k++) begin
      got = -1;
      if (bits_got.size() >= 24 * (k + 1)) begin
        for (int b = 0; b < 24; b++) acc[23-b] = bits_got[24*k + b][0];
        got = int'(acc);
        if (k == 0) px0 = acc;
      end
      check($sformatf("n%0d_pixel%0d_grb", n, k), got, int'(wire_grb(colours[k], bri)));
    end
  endtask

  typedef struct {
    int n;
    int pat;      // 0: all FF0000, 1: {idx,A5,3C}
    bit disturb;
    int done_exp;
  } vec_t;

  vec_t vt [4];
  logic [23:0] px;
  int cnt;

  initial begin
    vt[0] = '{n: 1, pat: 0, disturb: 1'b0, done_exp: 2490};
    vt[1] = '{n: 3, pat: 1, disturb: 1'b0, done_exp: 5466};
    vt[2] = '{n: 2, pat: 0, disturb: 1'b1, done_exp: 3978};
    vt[3] = '{n: 4, pat: 1, disturb: 1'b0, done_exp: 6954};

    reset = 1'b1; start = 1'b0; num_leds = '0;
`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    repeat (3) @(negedge clock);
    check("reset_outputs", int'({dout, busy, done, pixel_req}), 0);
    check("reset_pixel_idx", int'(pixel_idx), 0);
    reset = 1'b0;

    foreach (vt[v]) begin
      for (int k = 0; k < vt[v].n; k++) begin
        logic [9:0] kk;
        kk = 10'(k);
        colours[k] = (vt[v].pat == 0) ? 24'hFF0000 : {kk[7:0], 8'hA5, 8'h3C};
      end
      run_frame(vt[v].n, vt[v].done_exp, vt[v].disturb, 8'd255, px);
      if (vt[v].pat == 0) check("red_frame_first_pixel", int'(px), int'(24'h00FF00));
    end

    // Zero-length frame request must be ignored entirely.
    @(negedge clock);
    num_leds = '0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy || done || dout || pixel_req) cnt++;
      @(negedge clock);
    end
    check("num0_activity_cycles", cnt, 0);

    // Reset asserted while the line is high.
    colours[0] = 24'h123456;
    @(negedge clock);
    num_leds = 10'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 20 && dout !== 1'b1; i++) @(negedge clock);
    check("reset_test_reached_high", int'(dout), 1);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", int'({dout, busy, done, pixel_req}), 0);
    @(negedge clock);
    reset = 1'b0;
    run_frame(1, -1, 1'b0, 8'd255, px);

`ifdef WS2812_BRIGHTNESS_EN
    colours[0] = 24'hFF8040;
    run_frame(1, -1, 1'b0, 8'd127, px);
    check("brightness127_bytes", int'(px), int'(24'h407F20));
`endif

    for (int r = 0; r < 4; r++) begin
      int n;
      logic [7:0] bri;
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) colours[k] = 24'($urandom);
`ifdef WS2812_BRIGHTNESS_EN
      bri = 8'($urandom);
`else
      bri = 8'd255;
`endif
      run_frame(n, -1, 1'b0, bri, px);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
